// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one data-memory port between instruction fetch and
//            load/store. One transaction at a time, read-modify-write for
//            sub-word stores, load sign/zero extension, misalignment rejection.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ifReq,
    input  logic [ADDR_WIDTH-1:0] ifAddr,
    output logic                  ifGnt,
    output logic                  ifValid,
    output logic [DATA_WIDTH-1:0] ifData,
    input  logic                  lsReq,
    input  logic                  lsWe,
    input  logic [2:0]            lsFunc3,
    input  logic [ADDR_WIDTH-1:0] lsAddr,
    input  logic [DATA_WIDTH-1:0] lsWData,
    output logic                  lsGnt,
    output logic                  lsValid,
    output logic                  lsErr,
    output logic [DATA_WIDTH-1:0] lsRData,
    output logic [ADDR_WIDTH-1:0] memAddr,
    input  logic [DATA_WIDTH-1:0] memReadData,
    output logic                  memWriteEnable,
    output logic [DATA_WIDTH-1:0] memWriteData
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACCESS = 3'd1;
    localparam logic [2:0] ST_RMW_RD = 3'd2;
    localparam logic [2:0] ST_RMW_WR = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] C_WORD_MASK = ~ADDR_WIDTH'(3);
    localparam logic [3:0]            C_STARVE    = 4'(STARVE_LIMIT);

    logic [2:0]            state_q, state_d;
    logic [3:0]            starve_q, starve_d;
    logic                  is_ls_q, is_ls_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic [2:0]            func3_q, func3_d;
    logic [1:0]            off_q, off_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] if_data_q, if_data_d;
    logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;

    logic                  w_idle;
    logic                  w_if_wins;
    logic                  w_ls_legal;
    logic [4:0]            w_shamt;
    logic [DATA_WIDTH-1:0] w_lane;
    logic [DATA_WIDTH-1:0] w_load_val;
    logic [DATA_WIDTH-1:0] w_lane_mask;
    logic [DATA_WIDTH-1:0] w_merged;

    // Grants are only possible in IDLE and never while reset is held low.
    assign w_idle    = reset && (state_q == ST_IDLE);
    // Fetch wins when alone, or when it has been starved up to the limit.
    assign w_if_wins = ifReq && (!lsReq || (starve_q == C_STARVE));

    // Alignment and func3 legality of the presented load/store request.
    always_comb begin
        w_ls_legal = 1'b0;
        case (lsFunc3)
            3'd0, 3'd4: w_ls_legal = 1'b1;
            3'd1, 3'd5: w_ls_legal = ~lsAddr[0];
            3'd2:       w_ls_legal = (lsAddr[1:0] == 2'b00);
            default:    w_ls_legal = 1'b0;
        endcase
        if (lsWe && lsFunc3[2]) begin
            w_ls_legal = 1'b0;
        end
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        w_shamt     = {off_q, 3'b000};
        w_lane      = memReadData >> w_shamt;
        w_load_val  = w_lane;
        case (func3_q)
            3'd0:    w_load_val = {{(DATA_WIDTH-8){w_lane[7]}}, w_lane[7:0]};
            3'd1:    w_load_val = {{(DATA_WIDTH-16){w_lane[15]}}, w_lane[15:0]};
            3'd4:    w_load_val = {{(DATA_WIDTH-8){1'b0}}, w_lane[7:0]};
            3'd5:    w_load_val = {{(DATA_WIDTH-16){1'b0}}, w_lane[15:0]};
            default: w_load_val = w_lane;
        endcase
        w_lane_mask = (func3_q[0] ? DATA_WIDTH'(16'hFFFF) : DATA_WIDTH'(8'hFF)) << w_shamt;
        w_merged    = (memReadData & ~w_lane_mask)
                    | ((DATA_WIDTH'(wdata_q) << w_shamt) & w_lane_mask);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ifGnt) begin
                    state_d = ST_ACCESS;
                end else if (lsGnt) begin
                    if (!w_ls_legal)                    state_d = ST_RESP;
                    else if (lsWe && lsFunc3 != 3'd2)   state_d = ST_RMW_RD;
                    else                                state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RMW_RD: state_d = ST_RMW_WR;
            ST_RMW_WR: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake grants and completion pulses.
    always_comb begin
        ifGnt   = w_idle && w_if_wins;
        lsGnt   = w_idle && lsReq && !w_if_wins;
        ifValid = (state_q == ST_RESP) && !is_ls_q;
        lsValid = (state_q == ST_RESP) && is_ls_q;
        lsErr   = (state_q == ST_RESP) && is_ls_q && err_q;
    end

    // Datapath: request capture, memory port drive and response data.
    always_comb begin
        starve_d    = starve_q;
        is_ls_d     = is_ls_q;
        we_d        = we_q;
        err_d       = err_q;
        func3_d     = func3_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        if_data_d   = if_data_q;
        ls_rdata_d  = ls_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (ifGnt) begin
                    is_ls_d    = 1'b0;
                    err_d      = 1'b0;
                    starve_d   = 4'd0;
                    mem_addr_d = ifAddr & C_WORD_MASK;
                end else if (lsGnt) begin
                    is_ls_d = 1'b1;
                    we_d    = lsWe;
                    func3_d = lsFunc3;
                    off_d   = lsAddr[1:0];
                    wdata_d = lsWData[15:0];
                    err_d   = ~w_ls_legal;
                    if (ifReq && starve_q != 4'hF) begin
                        starve_d = starve_q + 4'd1;
                    end
                    if (w_ls_legal) begin
                        mem_addr_d = lsAddr & C_WORD_MASK;
                        if (lsWe && lsFunc3 == 3'd2) begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = lsWData;
                        end
                    end else begin
                        // Rejected accesses report a zero result.
                        ls_rdata_d = '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (is_ls_q) begin
                    if (!we_q) ls_rdata_d = w_load_val;
                end else begin
                    if_data_d = memReadData;
                end
            end
            ST_RMW_RD: begin
                mem_we_d    = 1'b1;
                mem_wdata_d = w_merged;
            end
            default: ;
        endcase
    end

    // Datapath registers; asynchronous reset also kills any pending write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q    <= 4'd0;
            is_ls_q     <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            func3_q     <= 3'd0;
            off_q       <= 2'd0;
            wdata_q     <= 16'd0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            ls_rdata_q  <= '0;
        end else begin
            starve_q    <= starve_d;
            is_ls_q     <= is_ls_d;
            we_q        <= we_d;
            err_q       <= err_d;
            func3_q     <= func3_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign ifData         = if_data_q;
    assign lsRData        = ls_rdata_q;
    assign memAddr        = mem_addr_q;
    assign memWriteEnable = mem_we_q;
    assign memWriteData   = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed and randomized bench for mem_port_arbiter with a
//            byte-level reference memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        ifGnt;
    logic        ifValid;
    logic [31:0] ifData;
    logic        lsReq;
    logic        lsWe;
    logic [2:0]  lsFunc3;
    logic [31:0] lsAddr;
    logic [31:0] lsWData;
    logic        lsGnt;
    logic        lsValid;
    logic        lsErr;
    logic [31:0] lsRData;
    logic [31:0] memAddr;
    logic [31:0] memReadData;
    logic        memWriteEnable;
    logic [31:0] memWriteData;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    mem_port_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ifReq         (ifReq),
        .ifAddr        (ifAddr),
        .ifGnt         (ifGnt),
        .ifValid       (ifValid),
        .ifData        (ifData),
        .lsReq         (lsReq),
        .lsWe          (lsWe),
        .lsFunc3       (lsFunc3),
        .lsAddr        (lsAddr),
        .lsWData       (lsWData),
        .lsGnt         (lsGnt),
        .lsValid       (lsValid),
        .lsErr         (lsErr),
        .lsRData       (lsRData),
        .memAddr       (memAddr),
        .memReadData   (memReadData),
        .memWriteEnable(memWriteEnable),
        .memWriteData  (memWriteData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory (4 KiB) and its preload port.
    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        tb_wr;
    logic [9:0]  tb_wa;
    logic [31:0] tb_wd;

    always @(posedge clk) begin
        if (memWriteEnable) mem[memAddr[11:2]] <= memWriteData;
        if (tb_wr)          mem[tb_wa]         <= tb_wd;
    end
    assign memReadData = mem[memAddr[11:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h (failure %0d)", tag, obs, exp, fails);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        tb_wr = 1'b1; tb_wa = a[11:2]; tb_wd = v;
        ref_mem[a[11:2]] = v;
        @(negedge clk);
        tb_wr = 1'b0;
    endtask

    // Reference model: access size/alignment rules.
    function automatic bit model_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        case (f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    return 1'b0;
        endcase
        if (we && f3 > 3'd2) return 1'b0;
        return (int'(a[1:0]) % sz) == 0;
    endfunction

    // Reference model: load result from the byte view of the word.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [7:0]  b [4];
        logic [31:0] w;
        int          off;
        w   = ref_mem[a[11:2]];
        off = int'(a[1:0]);
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        case (f3)
            3'd0:    return {{24{b[off][7]}}, b[off]};
            3'd4:    return {24'h0, b[off]};
            3'd1:    return {{16{b[off+1][7]}}, b[off+1], b[off]};
            3'd5:    return {16'h0, b[off+1], b[off]};
            default: return w;
        endcase
    endfunction

    // Reference model: memory word after a store.
    function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] a,
                                                input logic [31:0] d);
        logic [7:0]  b [4];
        logic [31:0] w;
        int          off;
        int          n;
        w   = ref_mem[a[11:2]];
        off = int'(a[1:0]);
        n   = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        for (int i = 0; i < n; i++) b[off+i] = d[8*i +: 8];
        return {b[3], b[2], b[1], b[0]};
    endfunction

    task automatic ls_txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input string tag);
        bit          ok;
        int          lat, n, vk, vcnt, wcnt, wk, idx;
        logic [31:0] exp_rd, exp_word, rd, wdat;
        logic        err;
        ok       = model_legal(we, f3, a);
        idx      = int'(a[11:2]);
        lat      = !ok ? 1 : (we && f3 != 3'd2) ? 3 : 2;
        exp_rd   = (ok && !we) ? model_load(f3, a) : 32'h0;
        exp_word = (ok && we) ? model_store(f3, a, wd) : ref_mem[idx];
        @(negedge clk);
        lsReq = 1'b1; lsWe = we; lsFunc3 = f3; lsAddr = a; lsWData = wd;
        #1;
        n = 0;
        while (!lsGnt && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check({tag, "_gnt"}, 32'(lsGnt), 32'd1);
        if (!lsGnt) begin
            lsReq = 1'b0;
            return;
        end
        vk = 0; vcnt = 0; wcnt = 0; wk = 0; rd = '0; err = 1'b0; wdat = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                lsReq = 1'b0; lsAddr = $urandom; lsWData = $urandom; lsFunc3 = 3'($urandom);
            end
            if (lsValid) begin
                vcnt++;
                if (vk == 0) begin vk = k; rd = lsRData; err = lsErr; end
            end
            if (memWriteEnable) begin wcnt++; wk = k; wdat = memWriteData; end
        end
        check({tag, "_lat"},    32'(vk),   32'(lat));
        check({tag, "_vcnt"},   32'(vcnt), 32'd1);
        check({tag, "_err"},    32'(err),  32'(!ok));
        if (!(ok && we)) check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_wcnt"},   32'(wcnt), 32'((ok && we) ? 1 : 0));
        if (ok && we) begin
            check({tag, "_wcyc"},  32'(wk), 32'((f3 == 3'd2) ? 1 : 2));
            check({tag, "_wdata"}, wdat, exp_word);
            ref_mem[idx] = exp_word;
        end
        check({tag, "_mem"}, mem[idx], ref_mem[idx]);
    endtask

    task automatic fetch_txn(input logic [31:0] a, input string tag);
        int          n, vk, vcnt, wcnt;
        logic [31:0] d;
        @(negedge clk);
        ifReq = 1'b1; ifAddr = a;
        #1;
        n = 0;
        while (!ifGnt && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check({tag, "_gnt"}, 32'(ifGnt), 32'd1);
        if (!ifGnt) begin
            ifReq = 1'b0;
            return;
        end
        vk = 0; vcnt = 0; wcnt = 0; d = '0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin ifReq = 1'b0; ifAddr = $urandom; end
            if (ifValid) begin
                vcnt++;
                if (vk == 0) begin vk = k; d = ifData; end
            end
            if (memWriteEnable) wcnt++;
        end
        check({tag, "_lat"},  32'(vk),   32'd2);
        check({tag, "_vcnt"}, 32'(vcnt), 32'd1);
        check({tag, "_data"}, d,         ref_mem[a[11:2]]);
        check({tag, "_wcnt"}, 32'(wcnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int grants, den, n;
        bit exp_if;
        bit we;
        logic [2:0]  f3;
        logic [31:0] a;

        reset = 1'b0; tb_wr = 1'b0; tb_wa = '0; tb_wd = '0;
        ifReq = 1'b1; ifAddr = 32'h100;
        lsReq = 1'b1; lsWe = 1'b0; lsFunc3 = 3'd2; lsAddr = 32'h100; lsWData = '0;

        // Reset state, with both requests pending.
        repeat (2) @(negedge clk);
        #1;
        check("rst_ifGnt",   32'(ifGnt),          32'd0);
        check("rst_lsGnt",   32'(lsGnt),          32'd0);
        check("rst_ifValid", 32'(ifValid),        32'd0);
        check("rst_lsValid", 32'(lsValid),        32'd0);
        check("rst_lsErr",   32'(lsErr),          32'd0);
        check("rst_ifData",  ifData,              32'd0);
        check("rst_lsRData", lsRData,             32'd0);
        check("rst_memAddr", memAddr,             32'd0);
        check("rst_memWe",   32'(memWriteEnable), 32'd0);
        check("rst_memWd",   memWriteData,        32'd0);
        ifReq = 1'b0; lsReq = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Word and sub-word loads.
        preload(32'h100, 32'hDEADBEEF);
        ls_txn(1'b0, 3'd2, 32'h100, 32'h0, "lw100");
        preload(32'h200, 32'h80FF1234);
        ls_txn(1'b0, 3'd0, 32'h203, 32'h0, "lb203");
        ls_txn(1'b0, 3'd4, 32'h203, 32'h0, "lbu203");
        ls_txn(1'b0, 3'd1, 32'h202, 32'h0, "lh202");
        ls_txn(1'b0, 3'd5, 32'h200, 32'h0, "lhu200");
        fetch_txn(32'h200, "if200");

        // Stores: RMW byte, RMW half, word.
        preload(32'h100, 32'h11223344);
        ls_txn(1'b1, 3'd0, 32'h101, 32'h123456AA, "sb101");
        ls_txn(1'b0, 3'd2, 32'h100, 32'h0, "lw100b");
        ls_txn(1'b1, 3'd1, 32'h102, 32'hFFFFBEEF, "sh102");
        preload(32'h104, 32'h01020304);
        ls_txn(1'b1, 3'd2, 32'h104, 32'hCAFEF00D, "sw104");

        // Misaligned and illegal func3.
        ls_txn(1'b0, 3'd2, 32'h102, 32'h0, "lw102");
        ls_txn(1'b1, 3'd1, 32'h101, 32'h5555, "sh101");
        ls_txn(1'b0, 3'd3, 32'h100, 32'h0, "f3_3");
        ls_txn(1'b1, 3'd4, 32'h100, 32'h77, "sbu");

        // Starvation: both requests held; model the priority rule directly.
        @(negedge clk);
        ifReq = 1'b1; ifAddr = 32'h104;
        lsReq = 1'b1; lsWe = 1'b0; lsFunc3 = 3'd2; lsAddr = 32'h100;
        grants = 0; den = 0;
        for (int c = 0; c < 200 && grants < 11; c++) begin
            #1;
            if (ifGnt || lsGnt) begin
                exp_if = (den == 4);
                check("starve_excl", 32'(ifGnt && lsGnt), 32'd0);
                check($sformatf("starve_g%0d", grants), 32'(ifGnt), 32'(exp_if));
                if (exp_if) den = 0;
                else        den++;
                grants++;
            end
            @(negedge clk);
        end
        check("starve_grants", 32'(grants), 32'd11);
        ifReq = 1'b0; lsReq = 1'b0;
        repeat (6) @(negedge clk);

        // Reset during RMW_RD of a byte store.
        preload(32'h300, 32'h55667788);
        @(negedge clk);
        lsReq = 1'b1; lsWe = 1'b1; lsFunc3 = 3'd0; lsAddr = 32'h301; lsWData = 32'hEE;
        #1;
        n = 0;
        while (!lsGnt && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("mid_gnt", 32'(lsGnt), 32'd1);
        @(negedge clk);
        lsReq = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("mid_memWe",   32'(memWriteEnable), 32'd0);
        check("mid_memAddr", memAddr,             32'd0);
        check("mid_outs",    32'(|{ifGnt, ifValid, ifData, lsGnt, lsValid, lsErr, lsRData,
                                   memWriteData}), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_noValid", 32'(lsValid || memWriteEnable), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("mid_mem", mem[32'h300 >> 2], 32'h55667788);
        ls_txn(1'b0, 3'd2, 32'h300, 32'h0, "after_rst");

        // Randomized single-requester traffic against the reference model.
        for (int i = 0; i < 8; i++) preload(32'h400 + 32'(4 * i), $urandom);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                fetch_txn(32'h400 + 32'(4 * $urandom_range(0, 7)), $sformatf("rif%0d", i));
            end else begin
                we = 1'($urandom_range(0, 1));
                if (we && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
                else                                 f3 = 3'($urandom_range(0, 7));
                a = 32'h400 + 32'($urandom_range(0, 31));
                ls_txn(we, f3, a, $urandom, $sformatf("rls%0d", i));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
